// File: rtl/pdm_audio_recorder_if.sv
// Signal bundle between the PDM recorder core and the board: buttons, microphone and audio output.
interface pdm_audio_recorder_if #(
    parameter int DEPTH = 1024
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              record_btn;
    logic              play_btn;
    logic              loop_en;
    logic              mic_data;
    logic              mic_clk;
    logic              mic_lrsel;
    logic              aud_pwm;
    logic              aud_en;
    logic              busy;
    logic [ADDR_W:0]   rec_len;

    modport master (
        output record_btn, play_btn, loop_en, mic_data,
        input  mic_clk, mic_lrsel, aud_pwm, aud_en, busy, rec_len
    );

    modport slave (
        input  record_btn, play_btn, loop_en, mic_data,
        output mic_clk, mic_lrsel, aud_pwm, aud_en, busy, rec_len
    );
endinterface

// File: rtl/pdm_audio_recorder.sv
// PDM microphone recorder: captures 1-bit PDM into an on-chip RAM and replays it as a 1-bit stream,
// all paced by the rising edge of the generated microphone clock.
module pdm_audio_recorder #(
    parameter int CLK_DIV = 25,
    parameter int WORD_W  = 32,
    parameter int DEPTH   = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    pdm_audio_recorder_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LEN_W  = ADDR_W + 1;
    localparam int BIT_W  = $clog2(WORD_W);

    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [7:0]         div_cnt;
    logic               mic_clk_q;
    logic               bit_tick;

    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   rec_len_q;
    logic [BIT_W-1:0]   bit_cnt;
    logic [WORD_W-1:0]  in_shreg;
    logic [WORD_W-1:0]  out_shreg;
    logic [WORD_W-1:0]  rd_data;
    logic [WORD_W-1:0]  mem [DEPTH];

    logic               wr_pending;
    logic               last_word;
    logic               pwm_bit;
    logic               rec_hold;
    logic               play_hold;
    logic               ram_we;

    logic               start_record;
    logic               start_play;
    logic               rec_sample;
    logic               rec_full_stop;
    logic               play_shift;
    logic               play_end_stop;

    // bit_tick marks the clk cycle whose closing edge raises mic_clk.
    assign bit_tick = (div_cnt == DIV_LAST) && !mic_clk_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt   <= '0;
            mic_clk_q <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            mic_clk_q <= ~mic_clk_q;
        end else begin
            div_cnt   <= div_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        start_record  = 1'b0;
        start_play    = 1'b0;
        rec_sample    = 1'b0;
        rec_full_stop = 1'b0;
        play_shift    = 1'b0;
        play_end_stop = 1'b0;
        case (state)
            IDLE: begin
                if (bit_tick) begin
                    if (bus.record_btn && !rec_hold) begin
                        state_next   = RECORD;
                        start_record = 1'b1;
                    end else if (!bus.record_btn && bus.play_btn && !play_hold
                                 && (rec_len_q != '0)) begin
                        state_next = PLAY;
                        start_play = 1'b1;
                    end
                end
            end
            RECORD: begin
                if (wr_pending && (rec_len_q == FULL_LEN - 1'b1)) begin
                    state_next    = IDLE;
                    rec_full_stop = 1'b1;
                end else if (bit_tick) begin
                    if (!bus.record_btn) begin
                        state_next = IDLE;
                    end else begin
                        rec_sample = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (bit_tick) begin
                    if (bus.record_btn || !bus.play_btn) begin
                        state_next = IDLE;
                    end else if ((bit_cnt == '0) && last_word && !bus.loop_en) begin
                        state_next    = IDLE;
                        play_end_stop = 1'b1;
                    end else begin
                        play_shift = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A held button must be released before the same action restarts after a natural stop
    // (memory full or end of non-looping playback); otherwise it would immediately retrigger.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr       <= '0;
            rec_len_q  <= '0;
            bit_cnt    <= '0;
            in_shreg   <= '0;
            out_shreg  <= '0;
            wr_pending <= 1'b0;
            last_word  <= 1'b0;
            pwm_bit    <= 1'b0;
            rec_hold   <= 1'b0;
            play_hold  <= 1'b0;
        end else begin
            wr_pending <= 1'b0;
            if (!bus.record_btn) begin
                rec_hold <= 1'b0;
            end
            if (!bus.play_btn) begin
                play_hold <= 1'b0;
            end
            if (rec_full_stop) begin
                rec_hold <= 1'b1;
            end
            if (play_end_stop) begin
                play_hold <= 1'b1;
            end

            if (start_record) begin
                addr      <= '0;
                bit_cnt   <= '0;
                rec_len_q <= '0;
            end

            if (start_play) begin
                addr      <= '0;
                bit_cnt   <= '0;
                last_word <= 1'b0;
                pwm_bit   <= 1'b0;
            end

            if (rec_sample) begin
                in_shreg <= {in_shreg[WORD_W-2:0], bus.mic_data};
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt    <= '0;
                    wr_pending <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (ram_we) begin
                addr      <= addr + 1'b1;
                rec_len_q <= rec_len_q + 1'b1;
            end

            // The next word is fetched as soon as the current one is loaded, so it is ready long
            // before its first bit is due; after the last word the fetch wraps to word 0.
            if (play_shift) begin
                if (bit_cnt == '0) begin
                    pwm_bit   <= rd_data[WORD_W-1];
                    out_shreg <= {rd_data[WORD_W-2:0], 1'b0};
                    last_word <= (({1'b0, addr} + 1'b1) == rec_len_q);
                    if (({1'b0, addr} + 1'b1) == rec_len_q) begin
                        addr <= '0;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end else begin
                    pwm_bit   <= out_shreg[WORD_W-1];
                    out_shreg <= {out_shreg[WORD_W-2:0], 1'b0};
                end
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    assign ram_we = wr_pending && (state == RECORD);

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[addr] <= in_shreg;
        end
        rd_data <= mem[addr];
    end

    assign bus.mic_clk   = mic_clk_q;
    assign bus.mic_lrsel = 1'b0;
    assign bus.aud_en    = (state == PLAY);
    assign bus.aud_pwm   = pwm_bit && (state == PLAY);
    assign bus.busy      = (state != IDLE);
    assign bus.rec_len   = rec_len_q;

endmodule
